// File: rtl/alu_cmd_sequencer.sv
// rtl/alu_cmd_sequencer.sv - single-command initiator for the Arith/Logic/CMP/Shift ALU units
// Accepts one command, pulses the chosen unit enable, waits for its Flag (or times out), returns the result.
module alu_cmd_sequencer #(
  parameter int A_WIDTH = 16,
  parameter int B_WIDTH = 16,
  parameter int TIMEOUT = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       cmd_valid,
  output logic                       cmd_ready,
  input  logic [3:0]                 cmd_func,
  input  logic [A_WIDTH-1:0]         cmd_a,
  input  logic [B_WIDTH-1:0]         cmd_b,
  output logic                       res_valid,
  input  logic                       res_ready,
  output logic [A_WIDTH+B_WIDTH-1:0] res_data,
  output logic [1:0]                 res_unit,
  output logic                       res_err,
  output logic [A_WIDTH-1:0]         A,
  output logic [B_WIDTH-1:0]         B,
  output logic [1:0]                 ALU_FUNC,
  output logic                       Arith_Enable,
  output logic                       Logic_Enable,
  output logic                       CMP_Enable,
  output logic                       Shift_Enable,
  input  logic [A_WIDTH+B_WIDTH-1:0] Arith_OUT,
  input  logic [A_WIDTH+B_WIDTH-1:0] Logic_OUT,
  input  logic [A_WIDTH+B_WIDTH-1:0] CMP_OUT,
  input  logic [A_WIDTH+B_WIDTH-1:0] Shift_OUT,
  input  logic                       Arith_Flag,
  input  logic                       Logic_Flag,
  input  logic                       CMP_Flag,
  input  logic                       Shift_Flag
);

  localparam int R_W = A_WIDTH + B_WIDTH;
  localparam int TW  = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT - 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  logic [1:0]         r_state;
  logic [1:0]         r_unit;
  logic [A_WIDTH-1:0] r_a;
  logic [B_WIDTH-1:0] r_b;
  logic [1:0]         r_func;
  logic [TW-1:0]      r_timer;
  logic [R_W-1:0]     r_res_data;
  logic [1:0]         r_res_unit;
  logic               r_res_err;
  logic [3:0]         r_enable;

  logic               w_accept;
  logic               w_sel_flag;
  logic [R_W-1:0]     w_sel_out;
  logic [3:0]         w_onehot;

  assign w_accept = cmd_valid && (r_state == S_IDLE);

  // Only the unit that was issued is listened to; stray Flags from the others are ignored.
  always_comb begin
    w_sel_flag = 1'b0;
    w_sel_out  = '0;
    case (r_unit)
      2'd0: begin w_sel_flag = Arith_Flag; w_sel_out = Arith_OUT; end
      2'd1: begin w_sel_flag = Logic_Flag; w_sel_out = Logic_OUT; end
      2'd2: begin w_sel_flag = CMP_Flag;   w_sel_out = CMP_OUT;   end
      default: begin w_sel_flag = Shift_Flag; w_sel_out = Shift_OUT; end
    endcase
  end

  always_comb begin
    w_onehot = 4'b0000;
    case (cmd_func[3:2])
      2'd0: w_onehot = 4'b0001;
      2'd1: w_onehot = 4'b0010;
      2'd2: w_onehot = 4'b0100;
      default: w_onehot = 4'b1000;
    endcase
  end

  // Enable is registered at the accept edge so it is high exactly for the ISSUE cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_enable <= 4'b0000;
    end else if (w_accept) begin
      r_enable <= w_onehot;
    end else begin
      r_enable <= 4'b0000;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= S_IDLE;
      r_unit     <= 2'd0;
      r_a        <= '0;
      r_b        <= '0;
      r_func     <= 2'd0;
      r_timer    <= '0;
      r_res_data <= '0;
      r_res_unit <= 2'd0;
      r_res_err  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (cmd_valid) begin
            r_a     <= cmd_a;
            r_b     <= cmd_b;
            r_func  <= cmd_func[1:0];
            r_unit  <= cmd_func[3:2];
            r_state <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          r_timer <= '0;
          r_state <= S_WAIT;
        end
        S_WAIT: begin
          if (w_sel_flag) begin
            r_res_data <= w_sel_out;
            r_res_unit <= r_unit;
            r_res_err  <= 1'b0;
            r_state    <= S_DONE;
          end else if (r_timer == TIMER_LAST) begin
            r_res_data <= '0;
            r_res_unit <= r_unit;
            r_res_err  <= 1'b1;
            r_state    <= S_DONE;
          end else begin
            r_timer <= r_timer + 1'b1;
          end
        end
        S_DONE: begin
          if (res_ready) begin
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign cmd_ready    = (r_state == S_IDLE);
  assign res_valid    = (r_state == S_DONE);
  assign res_data     = r_res_data;
  assign res_unit     = r_res_unit;
  assign res_err      = r_res_err;
  assign A            = r_a;
  assign B            = r_b;
  assign ALU_FUNC     = r_func;
  assign Arith_Enable = r_enable[0];
  assign Logic_Enable = r_enable[1];
  assign CMP_Enable   = r_enable[2];
  assign Shift_Enable = r_enable[3];

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// tb/tb_alu_cmd_sequencer.sv - directed self-checking bench for alu_cmd_sequencer
module tb_alu_cmd_sequencer;

  logic        clk;
  logic        rst;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [3:0]  cmd_func;
  logic [15:0] cmd_a;
  logic [15:0] cmd_b;
  logic        res_valid;
  logic        res_ready;
  logic [31:0] res_data;
  logic [1:0]  res_unit;
  logic        res_err;
  logic [15:0] A;
  logic [15:0] B;
  logic [1:0]  ALU_FUNC;
  logic        Arith_Enable, Logic_Enable, CMP_Enable, Shift_Enable;
  logic [31:0] Arith_OUT, Logic_OUT, CMP_OUT, Shift_OUT;
  logic        Arith_Flag, Logic_Flag, CMP_Flag, Shift_Flag;

  int n_checks;
  int n_fail;

  alu_cmd_sequencer #(.A_WIDTH(16), .B_WIDTH(16), .TIMEOUT(4)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_func(cmd_func),
    .cmd_a(cmd_a), .cmd_b(cmd_b),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
    .res_unit(res_unit), .res_err(res_err),
    .A(A), .B(B), .ALU_FUNC(ALU_FUNC),
    .Arith_Enable(Arith_Enable), .Logic_Enable(Logic_Enable),
    .CMP_Enable(CMP_Enable), .Shift_Enable(Shift_Enable),
    .Arith_OUT(Arith_OUT), .Logic_OUT(Logic_OUT), .CMP_OUT(CMP_OUT), .Shift_OUT(Shift_OUT),
    .Arith_Flag(Arith_Flag), .Logic_Flag(Logic_Flag), .CMP_Flag(CMP_Flag), .Shift_Flag(Shift_Flag)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Presents a command at a negedge; returns at the negedge right after the accept edge.
  task automatic send_cmd(input logic [3:0] func, input logic [15:0] a, input logic [15:0] b);
    cmd_func  = func;
    cmd_a     = a;
    cmd_b     = b;
    cmd_valid = 1'b1;
    n_checks++; if (cmd_ready !== 1'b1) begin n_fail++; $display("FAIL send_ready: got %b want 1", cmd_ready); end
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  task automatic take_result();
    res_ready = 1'b1;
    @(negedge clk);
    res_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    cmd_valid = 1'b0; cmd_func = 4'h0; cmd_a = 16'h0; cmd_b = 16'h0; res_ready = 1'b0;
    Arith_OUT = 32'h0; Logic_OUT = 32'h0; CMP_OUT = 32'h0; Shift_OUT = 32'h0;
    Arith_Flag = 1'b0; Logic_Flag = 1'b0; CMP_Flag = 1'b0; Shift_Flag = 1'b0;
    repeat (3) @(negedge clk);
    n_checks++; if (cmd_ready !== 1'b1) begin n_fail++; $display("FAIL rst_cmd_ready: got %b want 1", cmd_ready); end
    n_checks++; if (res_valid !== 1'b0) begin n_fail++; $display("FAIL rst_res_valid: got %b want 0", res_valid); end
    n_checks++; if (res_err !== 1'b0) begin n_fail++; $display("FAIL rst_res_err: got %b want 0", res_err); end
    n_checks++; if (res_data !== 32'h0) begin n_fail++; $display("FAIL rst_res_data: got %h want 0", res_data); end
    n_checks++; if (res_unit !== 2'd0) begin n_fail++; $display("FAIL rst_res_unit: got %0d want 0", res_unit); end
    n_checks++; if ({A, B, ALU_FUNC} !== 34'h0) begin n_fail++; $display("FAIL rst_operands: got %h/%h/%b want 0", A, B, ALU_FUNC); end
    n_checks++; if ({Arith_Enable, Logic_Enable, CMP_Enable, Shift_Enable} !== 4'b0000) begin n_fail++; $display("FAIL rst_enables: got %b want 0000", {Arith_Enable, Logic_Enable, CMP_Enable, Shift_Enable}); end
    rst = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_shift();
    send_cmd(4'b1101, 16'h0005, 16'h0000);
    n_checks++; if ({Arith_Enable, Logic_Enable, CMP_Enable, Shift_Enable} !== 4'b0001) begin n_fail++; $display("FAIL shift_en_issue: got %b want 0001", {Arith_Enable, Logic_Enable, CMP_Enable, Shift_Enable}); end
    n_checks++; if (ALU_FUNC !== 2'b01) begin n_fail++; $display("FAIL shift_func: got %b want 01", ALU_FUNC); end
    n_checks++; if (cmd_ready !== 1'b0) begin n_fail++; $display("FAIL shift_busy: got %b want 0", cmd_ready); end
    @(negedge clk);
    n_checks++; if (Shift_Enable !== 1'b0) begin n_fail++; $display("FAIL shift_en_pulse: got %b want 0", Shift_Enable); end
    n_checks++; if (res_valid !== 1'b0) begin n_fail++; $display("FAIL shift_early_valid: got %b want 0", res_valid); end
    Shift_OUT  = {16'h0, A} << 1;
    Shift_Flag = 1'b1;
    @(negedge clk);
    Shift_Flag = 1'b0;
    n_checks++; if (res_valid !== 1'b1) begin n_fail++; $display("FAIL shift_valid: got %b want 1", res_valid); end
    n_checks++; if (res_data !== 32'h0000000A) begin n_fail++; $display("FAIL shift_data: got %h want 0000000a", res_data); end
    n_checks++; if (res_unit !== 2'd3) begin n_fail++; $display("FAIL shift_unit: got %0d want 3", res_unit); end
    n_checks++; if (res_err !== 1'b0) begin n_fail++; $display("FAIL shift_err: got %b want 0", res_err); end
    take_result();
    n_checks++; if (res_valid !== 1'b0) begin n_fail++; $display("FAIL shift_done: got %b want 0", res_valid); end
    n_checks++; if (cmd_ready !== 1'b1) begin n_fail++; $display("FAIL shift_idle: got %b want 1", cmd_ready); end
  endtask

  task automatic test_arith();
    send_cmd(4'b0000, 16'd3, 16'd4);
    n_checks++; if ({Arith_Enable, Logic_Enable, CMP_Enable, Shift_Enable} !== 4'b1000) begin n_fail++; $display("FAIL arith_en: got %b want 1000", {Arith_Enable, Logic_Enable, CMP_Enable, Shift_Enable}); end
    n_checks++; if ({A, B, ALU_FUNC} !== {16'd3, 16'd4, 2'b00}) begin n_fail++; $display("FAIL arith_operands: got %h/%h/%b want 0003/0004/00", A, B, ALU_FUNC); end
    @(negedge clk);
    Arith_OUT  = {16'h0, A} + {16'h0, B};
    Arith_Flag = 1'b1;
    @(negedge clk);
    Arith_Flag = 1'b0;
    n_checks++; if (res_valid !== 1'b1) begin n_fail++; $display("FAIL arith_valid: got %b want 1", res_valid); end
    n_checks++; if (res_data !== 32'd7) begin n_fail++; $display("FAIL arith_data: got %h want 7", res_data); end
    n_checks++; if (res_unit !== 2'd0) begin n_fail++; $display("FAIL arith_unit: got %0d want 0", res_unit); end
    take_result();
  endtask

  task automatic test_timeout();
    int cyc;
    send_cmd(4'b0100, 16'h1111, 16'h2222);
    n_checks++; if (Logic_Enable !== 1'b1) begin n_fail++; $display("FAIL to_en: got %b want 1", Logic_Enable); end
    cyc = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      cyc++;
      if (res_valid === 1'b1) break;
    end
    n_checks++; if (cyc !== 5) begin n_fail++; $display("FAIL to_latency: got %0d cycles want 5", cyc); end
    n_checks++; if (res_err !== 1'b1) begin n_fail++; $display("FAIL to_err: got %b want 1", res_err); end
    n_checks++; if (res_data !== 32'h0) begin n_fail++; $display("FAIL to_data: got %h want 0", res_data); end
    n_checks++; if (res_unit !== 2'd1) begin n_fail++; $display("FAIL to_unit: got %0d want 1", res_unit); end
    Logic_OUT  = 32'h00001234;
    Logic_Flag = 1'b1;
    @(negedge clk);
    n_checks++; if ({res_valid, res_err, res_data} !== {1'b1, 1'b1, 32'h0}) begin n_fail++; $display("FAIL to_late_flag: got v=%b e=%b d=%h want 1/1/0", res_valid, res_err, res_data); end
    take_result();
    @(negedge clk);
    Logic_Flag = 1'b0;
    n_checks++; if ({cmd_ready, res_valid} !== 2'b10) begin n_fail++; $display("FAIL to_idle: got ready=%b valid=%b want 1/0", cmd_ready, res_valid); end
  endtask

  task automatic test_back_to_back();
    send_cmd(4'b0010, 16'd1, 16'd2);
    @(negedge clk);
    Arith_OUT  = 32'd3;
    Arith_Flag = 1'b1;
    @(negedge clk);
    Arith_Flag = 1'b0;
    cmd_func = 4'b0000; cmd_a = 16'd5; cmd_b = 16'd6; cmd_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      n_checks++; if ({res_valid, cmd_ready, res_data} !== {1'b1, 1'b0, 32'd3}) begin n_fail++; $display("FAIL bp_hold%0d: got v=%b r=%b d=%h want 1/0/3", i, res_valid, cmd_ready, res_data); end
      @(negedge clk);
    end
    n_checks++; if (A !== 16'd1) begin n_fail++; $display("FAIL bp_no_accept: got A=%h want 1", A); end
    take_result();
    n_checks++; if ({res_valid, cmd_ready, Arith_Enable} !== 3'b010) begin n_fail++; $display("FAIL bp_release: got v=%b r=%b en=%b want 0/1/0", res_valid, cmd_ready, Arith_Enable); end
    @(negedge clk);
    cmd_valid = 1'b0;
    n_checks++; if ({Arith_Enable, A, B} !== {1'b1, 16'd5, 16'd6}) begin n_fail++; $display("FAIL bp_second: got en=%b A=%h B=%h want 1/5/6", Arith_Enable, A, B); end
    @(negedge clk);
    Arith_OUT  = 32'd11;
    Arith_Flag = 1'b1;
    @(negedge clk);
    Arith_Flag = 1'b0;
    n_checks++; if ({res_valid, res_data} !== {1'b1, 32'd11}) begin n_fail++; $display("FAIL bp_second_res: got v=%b d=%h want 1/b", res_valid, res_data); end
    take_result();
  endtask

  task automatic test_wrong_flag();
    send_cmd(4'b1000, 16'h00AA, 16'h00BB);
    n_checks++; if (CMP_Enable !== 1'b1) begin n_fail++; $display("FAIL wf_en: got %b want 1", CMP_Enable); end
    @(negedge clk);
    Shift_OUT  = 32'hDEAD;
    Shift_Flag = 1'b1;
    @(negedge clk);
    Shift_Flag = 1'b0;
    n_checks++; if (res_valid !== 1'b0) begin n_fail++; $display("FAIL wf_ignored: got %b want 0", res_valid); end
    CMP_OUT  = 32'h1;
    CMP_Flag = 1'b1;
    @(negedge clk);
    CMP_Flag = 1'b0;
    n_checks++; if ({res_valid, res_data, res_unit, res_err} !== {1'b1, 32'h1, 2'd2, 1'b0}) begin n_fail++; $display("FAIL wf_result: got v=%b d=%h u=%0d e=%b want 1/1/2/0", res_valid, res_data, res_unit, res_err); end
    take_result();
  endtask

  task automatic test_reset_in_wait();
    send_cmd(4'b0011, 16'h0042, 16'h0043);
    @(negedge clk);
    #2 rst = 1'b0;
    #1;
    n_checks++; if ({cmd_ready, res_valid, res_err} !== 3'b100) begin n_fail++; $display("FAIL rw_ctrl: got r=%b v=%b e=%b want 1/0/0", cmd_ready, res_valid, res_err); end
    n_checks++; if ({A, B, ALU_FUNC, res_data, res_unit} !== 68'h0) begin n_fail++; $display("FAIL rw_data: got A=%h B=%h f=%b d=%h u=%0d want 0", A, B, ALU_FUNC, res_data, res_unit); end
    Arith_OUT  = 32'h55;
    Arith_Flag = 1'b1;
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_checks++; if ({cmd_ready, res_valid} !== 2'b10) begin n_fail++; $display("FAIL rw_after%0d: got r=%b v=%b want 1/0", i, cmd_ready, res_valid); end
    end
    Arith_Flag = 1'b0;
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    test_reset();
    test_shift();
    test_arith();
    test_timeout();
    test_back_to_back();
    test_wrong_flag();
    test_reset_in_wait();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
